// File: rtl/cpu_ctrl_fsm_v2_pkg.sv
// Shared constants for the RISC control FSM: state codes, memory commands,
// register/writeback/PC selects, instruction opcodes and branch condition codes.
package cpu_ctrl_pkg;

  localparam int CTRL_STATE_W = 5;

  // State encoding (stable codes, also visible on dbg_state)
  localparam logic [4:0] S_RESET   = 5'd0;
  localparam logic [4:0] S_IF1     = 5'd1;
  localparam logic [4:0] S_IF_WAIT = 5'd2;
  localparam logic [4:0] S_IF2     = 5'd3;
  localparam logic [4:0] S_UPD_PC  = 5'd4;
  localparam logic [4:0] S_DECODE  = 5'd5;
  localparam logic [4:0] S_WR_IMM  = 5'd6;
  localparam logic [4:0] S_GET_A   = 5'd7;
  localparam logic [4:0] S_GET_BM  = 5'd8;   // load B from Rm
  localparam logic [4:0] S_GET_BD  = 5'd9;   // load B from Rd
  localparam logic [4:0] S_ALU     = 5'd10;  // C = A op B
  localparam logic [4:0] S_ALU_Z   = 5'd11;  // C = 0 op B (MOV shift, MVN)
  localparam logic [4:0] S_WR_RD   = 5'd12;
  localparam logic [4:0] S_CMP     = 5'd13;
  localparam logic [4:0] S_ADR     = 5'd14;
  localparam logic [4:0] S_LD_ADDR = 5'd15;
  localparam logic [4:0] S_RD_MEM  = 5'd16;
  localparam logic [4:0] S_WR_MEM  = 5'd17;
  localparam logic [4:0] S_PASS    = 5'd18;
  localparam logic [4:0] S_WR_RAM  = 5'd19;
  localparam logic [4:0] S_BR      = 5'd20;
  localparam logic [4:0] S_LINK    = 5'd21;
  localparam logic [4:0] S_JMP     = 5'd22;
  localparam logic [4:0] S_HALT    = 5'd23;

  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_WRITE = 2'b10;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_CALL = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_SH  = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_B       = 2'b00;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;
  localparam logic [1:0] OP_BL      = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

endpackage

// File: rtl/cpu_ctrl_fsm_v2_if.sv
// Control bus between the FSM and the datapath/memory side.
// All signals are level controls held for whole cycles; there is no valid/ready
// handshake: the FSM drives Moore controls, the datapath samples them each edge.
interface cpu_ctrl_fsm_v2_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       Z, N, V;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads;
  logic       write;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       reset_pc, load_pc;
  logic [1:0] pc_sel;
  logic       addr_sel;
  logic       load_ir, load_addr;
  logic [1:0] mem_cmd;
  logic       halted;

  modport master (
    input  opcode, op, cond, Z, N, V,
    output nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           reset_pc, load_pc, pc_sel, addr_sel, load_ir, load_addr, mem_cmd, halted
  );

  modport slave (
    output opcode, op, cond, Z, N, V,
    input  nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel,
           reset_pc, load_pc, pc_sel, addr_sel, load_ir, load_addr, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_ctrl_fsm_v2_cond_eval.sv
// Branch condition evaluator: (cond, Z, N, V) -> taken. Purely combinational.
module cpu_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  // Codes 101..111 are reserved and never taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm_v2.sv
// Control FSM for the RISC machine: fetch/decode/execute for MOV, ALU, LDR,
// STR, HALT, conditional branch, BL, BX, BLX. RAM reads wait MEM_LAT extra cycles.
// Optional build macro CTRL_TRAP_EN: unlisted instructions halt and raise trap;
// without it they behave as NOPs and the trap port does not exist.
module cpu_ctrl_fsm_v2
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  cpu_ctrl_fsm_v2_if.master  bus,
  output logic [STATE_W-1:0] dbg_state
`ifdef CTRL_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  logic [4:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cond_true, is_bl, br_taken;
  logic [4:0]       ir_code;

  assign ir_code  = {bus.opcode, bus.op};
  assign is_bl    = (bus.opcode == OPC_CALL) && (bus.op == OP_BL);
  // BL reuses BR with the branch forced taken
  assign br_taken = cond_true | is_bl;

  cpu_cond_eval u_cond (
    .cond  (bus.cond),
    .z     (bus.Z),
    .n     (bus.N),
    .v     (bus.V),
    .taken (cond_true)
  );

  // State register; reset forces RESET immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_nx;
  end

  // Wait counter: loaded on IF1 / LD_ADDR, counts down through IF_WAIT / RD_MEM
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    cnt <= '0;
    else if (state == S_IF1 || state == S_LD_ADDR) cnt <= CNT_W'(MEM_LAT);
    else if ((state == S_IF_WAIT || state == S_RD_MEM) && cnt != '0)
                                                  cnt <= cnt - 1'b1;
  end

  // Next-state: IR fields are stable from DECODE until the next fetch
  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:   state_nx = S_IF1;
      S_IF1:     state_nx = (MEM_LAT == 0) ? S_IF2 : S_IF_WAIT;
      S_IF_WAIT: state_nx = (cnt <= CNT_W'(1)) ? S_IF2 : S_IF_WAIT;
      S_IF2:     state_nx = S_UPD_PC;
      S_UPD_PC:  state_nx = S_DECODE;
      S_DECODE: begin
        case (ir_code)
          {OPC_MOV, OP_MOV_IMM}: state_nx = S_WR_IMM;
          {OPC_MOV, OP_MOV_SH}:  state_nx = S_GET_BM;
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_AND},
          {OPC_ALU, OP_CMP},
          {OPC_LDR, OP_MEM},
          {OPC_STR, OP_MEM}:     state_nx = S_GET_A;
          {OPC_ALU, OP_MVN}:     state_nx = S_GET_BM;
          {OPC_BR,  OP_B}:       state_nx = S_BR;
          {OPC_CALL, OP_BL},
          {OPC_CALL, OP_BLX}:    state_nx = S_LINK;
          {OPC_CALL, OP_BX}:     state_nx = S_GET_BD;
          {OPC_HALT, 2'b00},
          {OPC_HALT, 2'b01},
          {OPC_HALT, 2'b10},
          {OPC_HALT, 2'b11}:     state_nx = S_HALT;
`ifdef CTRL_TRAP_EN
          default:               state_nx = S_HALT;
`else
          default:               state_nx = S_IF1;
`endif
        endcase
      end
      S_GET_A:   state_nx = (bus.opcode == OPC_LDR || bus.opcode == OPC_STR) ? S_ADR : S_GET_BM;
      S_GET_BM: begin
        if (bus.op == OP_CMP && bus.opcode == OPC_ALU)                          state_nx = S_CMP;
        else if (bus.opcode == OPC_ALU && (bus.op == OP_ADD || bus.op == OP_AND)) state_nx = S_ALU;
        else                                                                    state_nx = S_ALU_Z;
      end
      S_GET_BD:  state_nx = S_PASS;
      S_ALU:     state_nx = S_WR_RD;
      S_ALU_Z:   state_nx = S_WR_RD;
      S_WR_RD:   state_nx = S_IF1;
      S_CMP:     state_nx = S_IF1;
      S_ADR:     state_nx = S_LD_ADDR;
      S_LD_ADDR: state_nx = (bus.opcode == OPC_LDR) ? S_RD_MEM : S_GET_BD;
      S_RD_MEM:  state_nx = (cnt == '0) ? S_WR_MEM : S_RD_MEM;
      S_WR_MEM:  state_nx = S_IF1;
      S_PASS:    state_nx = (bus.opcode == OPC_STR) ? S_WR_RAM : S_JMP;
      S_WR_RAM:  state_nx = S_IF1;
      S_WR_IMM:  state_nx = S_IF1;
      S_BR:      state_nx = S_IF1;
      // LINK precedes the Rd read, so BLX R7 jumps to the fresh link value
      S_LINK:    state_nx = is_bl ? S_BR : S_GET_BD;
      S_JMP:     state_nx = S_IF1;
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_RESET;
    endcase
  end

  // Moore output decode; BR alone also looks at the live flags
  always_comb begin
    bus.nsel      = 3'b000;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.write     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.vsel      = VSEL_C;
    bus.reset_pc  = 1'b0;
    bus.load_pc   = 1'b0;
    bus.pc_sel    = PCSEL_INC;
    bus.addr_sel  = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_addr = 1'b0;
    bus.mem_cmd   = M_NONE;
    bus.halted    = 1'b0;
    case (state)
      S_RESET:   begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1,
      S_IF_WAIT: begin bus.addr_sel = 1'b1; bus.mem_cmd = M_READ; end
      S_IF2:     begin bus.addr_sel = 1'b1; bus.mem_cmd = M_READ; bus.load_ir = 1'b1; end
      S_UPD_PC:  begin bus.load_pc = 1'b1; bus.pc_sel = PCSEL_INC; end
      S_WR_IMM:  begin bus.nsel = NSEL_RN; bus.vsel = VSEL_IMM; bus.write = 1'b1; end
      S_GET_A:   begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GET_BM:  begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_GET_BD:  begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_ALU:     bus.loadc = 1'b1;
      S_ALU_Z,
      S_PASS:    begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_WR_RD:   begin bus.nsel = NSEL_RD; bus.vsel = VSEL_C; bus.write = 1'b1; end
      S_CMP:     bus.loads = 1'b1;
      S_ADR:     begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_LD_ADDR: bus.load_addr = 1'b1;
      S_RD_MEM:  bus.mem_cmd = M_READ;
      S_WR_MEM:  begin bus.nsel = NSEL_RD; bus.vsel = VSEL_MDATA; bus.write = 1'b1; bus.mem_cmd = M_READ; end
      S_WR_RAM:  bus.mem_cmd = M_WRITE;
      S_BR:      if (br_taken) begin bus.load_pc = 1'b1; bus.pc_sel = PCSEL_BR; end
      S_LINK:    begin bus.nsel = NSEL_RN; bus.vsel = VSEL_PC; bus.write = 1'b1; end
      S_JMP:     begin bus.load_pc = 1'b1; bus.pc_sel = PCSEL_REG; end
      S_HALT:    bus.halted = 1'b1;
      default:   ;
    endcase
  end

  assign dbg_state = STATE_W'(state);

`ifdef CTRL_TRAP_EN
  // Trap latches when DECODE halts on an unlisted code; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      trap <= 1'b0;
    else if (state == S_DECODE && state_nx == S_HALT && bus.opcode != OPC_HALT)
      trap <= 1'b1;
  end
`endif

endmodule
